// File: rtl/decoder_3_8_chaser.sv
// 3-to-8 one-hot LED decoder with a ping-pong chaser mode for the switch/LED board.
// All outputs are registered; pos is exported for the 7-segment display.
module decoder_3_8_chaser #(
  parameter int PRESCALE = 5000000,
  parameter int CNT_W    = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic [2:0] code,
  input  logic       code_valid,
  output logic [7:0] led,
  output logic [2:0] pos,
  output logic       step_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    CHASE_UP,
    CHASE_DOWN
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pos_q, pos_d;
  logic [7:0]       led_q, led_d;
  logic             step_q, step_d;
  logic             in_chase;

  function automatic logic [7:0] onehot(input logic [2:0] p);
    onehot = 8'd1 << p;
  endfunction

  assign in_chase = (state_q == CHASE_UP) || (state_q == CHASE_DOWN);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = '0;
    pos_d   = pos_q;
    led_d   = '0;
    step_d  = 1'b0;

    if (!en) begin
      state_d = IDLE;
    end else if (!mode) begin
      state_d = DIRECT;
      if (code_valid) begin
        pos_d = code;
        led_d = onehot(code);
      end
    end else if (!in_chase) begin
      // Entering the chase: light the retained position now, head away from the end we sit on.
      state_d = (pos_q == 3'd7) ? CHASE_DOWN : CHASE_UP;
      led_d   = onehot(pos_q);
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
      led_d = onehot(pos_q);
    end else begin
      step_d = 1'b1;
      if (state_q == CHASE_UP) begin
        pos_d = pos_q + 3'd1;
        if (pos_d == 3'd7) state_d = CHASE_DOWN;
      end else begin
        pos_d = pos_q - 3'd1;
        if (pos_d == 3'd0) state_d = CHASE_UP;
      end
      led_d = onehot(pos_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pos_q   <= '0;
      led_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      led_q   <= led_d;
      step_q  <= step_d;
    end
  end

  assign led        = led_q;
  assign pos        = pos_q;
  assign step_pulse = step_q;

endmodule

// File: tb/tb_decoder_3_8_chaser.sv
// Scoreboard bench for decoder_3_8_chaser: a behavioural model pushes expected outputs
// per clock edge, a negedge monitor pops and compares them against the DUT.
module tb_decoder_3_8_chaser;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] code = 3'd0;
  logic       code_valid = 1'b0;
  logic [7:0] led;
  logic [2:0] pos;
  logic       step_pulse;

  decoder_3_8_chaser #(.PRESCALE(P), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .code       (code),
    .code_valid (code_valid),
    .led        (led),
    .pos        (pos),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] led;
    logic [2:0] pos;
    logic       step;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: position, direction of travel and cycles since entry/last step.
  int         m_pos = 0;
  bit         m_chasing = 1'b0;
  int         m_dir = 1;
  int         m_ticks = 0;
  logic [7:0] m_led = 8'h00;
  bit         m_step = 1'b0;

  function automatic void model_reset();
    m_pos = 0; m_chasing = 1'b0; m_dir = 1; m_ticks = 0; m_led = 8'h00; m_step = 1'b0;
  endfunction

  function automatic void model_step(input bit e, input bit m, input int c, input bit v);
    m_step = 1'b0;
    if (!e) begin
      m_chasing = 1'b0;
      m_led = 8'h00;
    end else if (!m) begin
      m_chasing = 1'b0;
      if (v) m_pos = c;
      m_led = v ? (8'd1 << c) : 8'h00;
    end else if (!m_chasing) begin
      m_chasing = 1'b1;
      m_dir = (m_pos == 7) ? -1 : 1;
      m_ticks = 0;
      m_led = 8'd1 << m_pos;
    end else begin
      m_ticks++;
      if (m_ticks == P) begin
        m_ticks = 0;
        m_pos += m_dir;
        if (m_pos == 7) m_dir = -1;
        else if (m_pos == 0) m_dir = 1;
        m_step = 1'b1;
      end
      m_led = 8'd1 << m_pos;
    end
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic cycle(input bit e, input bit m, input int c, input bit v);
    en = e; mode = m; code = 3'(c); code_valid = v;
    @(posedge clk);
    model_step(e, m, c, v);
    exp_q.push_back('{led: m_led, pos: 3'(m_pos), step: m_step});
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear in the same delta.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_led", int'(led), 0);
    check("rst_pos", int'(pos), 0);
    check("rst_step", int'(step_pulse), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      vectors++;
      if (led !== mon_e.led || pos !== mon_e.pos || step_pulse !== mon_e.step) begin
        miscompares++;
        $display("FAIL out @%0t: led=%h pos=%0d step=%b, expected led=%h pos=%0d step=%b",
                 $time, led, pos, step_pulse, mon_e.led, mon_e.pos, mon_e.step);
      end
      vectors++;
      if ((led & (led - 8'd1)) != 8'h00) begin
        miscompares++;
        $display("FAIL onehot @%0t: led=%h, expected zero or one-hot", $time, led);
      end
    end
  end

  initial begin
    int steps;
    int m_steps;

    repeat (2) @(negedge clk);
    check("init_led", int'(led), 0);
    check("init_pos", int'(pos), 0);
    check("init_step", int'(step_pulse), 0);
    rst = 1'b0;
    model_reset();

    // Reset mid-chase at pos 5, then a direct decode of 3.
    for (int i = 0; i < 100 && m_pos != 5; i++) cycle(1, 1, 0, 0);
    check("t1_reach5", int'(pos), 5);
    cycle(1, 1, 0, 0);
    do_reset();
    cycle(1, 0, 3, 1);
    check("t1_led", int'(led), 'h08);
    check("t1_pos", int'(pos), 3);

    // Direct decode sweep, then code_valid low.
    for (int c = 0; c < 8; c++) begin
      cycle(1, 0, c, 1);
      check("t2_led", int'(led), 1 << c);
    end
    cycle(1, 0, 6, 0);
    check("t2_blank_led", int'(led), 0);
    check("t2_hold_pos", int'(pos), 7);

    // Ping-pong from pos 0 for 64 cycles.
    cycle(1, 0, 0, 1);
    steps = 0;
    m_steps = 0;
    for (int k = 0; k < 64; k++) begin
      cycle(1, 1, $urandom_range(0, 7), $urandom_range(0, 1));
      steps += int'(step_pulse);
      m_steps += int'(m_step);
    end
    check("t3_steps", steps, m_steps);
    check("t3_end_pos", int'(pos), 1);

    // Entry at the top end goes down.
    cycle(1, 0, 7, 1);
    cycle(1, 1, 0, 0);
    check("t4_led", int'(led), 'h80);
    repeat (3) cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check("t4_pos", int'(pos), 6);
    check("t4_step", int'(step_pulse), 1);

    // Enable gating at pos 4.
    cycle(1, 0, 0, 1);
    for (int i = 0; i < 100 && m_pos != 4; i++) cycle(1, 1, 0, 0);
    repeat (2) cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check("t5_off_led", int'(led), 0);
    steps = int'(step_pulse);
    for (int i = 0; i < 19; i++) begin
      cycle(0, 1, $urandom_range(0, 7), 1);
      steps += int'(step_pulse);
    end
    check("t5_no_step", steps, 0);
    check("t5_frozen", int'(pos), 4);
    cycle(1, 1, 0, 0);
    check("t5_on_led", int'(led), 'h10);
    repeat (4) cycle(1, 1, 0, 0);
    check("t5_next_pos", int'(pos), 5);

    // Mode toggle mid-count restarts the prescaler.
    repeat (2) cycle(1, 1, 0, 0);
    repeat (2) cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      cycle(1, 1, 0, 0);
      check("t6_step", int'(step_pulse), (k == 4) ? 1 : 0);
    end

    // Randomised segments with occasional asynchronous resets.
    for (int s = 0; s < 80; s++) begin
      bit e;
      bit m;
      int len;
      e = ($urandom_range(0, 9) != 0);
      m = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 99) == 0) do_reset();
        cycle(e, m, $urandom_range(0, 7), ($urandom_range(0, 3) != 0));
      end
    end

    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
